// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_if
//  Description : Signal bundle between the multicycle sequencer and the
//                datapath / memory handshakes of the RV32I core.
//                slave  modport : the sequencer (mc_ctrl)
//                master modport : the datapath / environment driving it
//  Signals     : opcode[6:0], imem_ack, dmem_ack, branch_taken   (to sequencer)
//                imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel[1:0],
//                rf_we, wb_sel[1:0], alu_a_sel[1:0], alu_b_sel, state[2:0],
//                illegal, timeout, instret[31:0]                 (from sequencer)
//  Revision    : 1.0  initial release
// ============================================================================
interface mc_ctrl_if;
    logic [6:0]  opcode;
    logic        imem_ack;
    logic        dmem_ack;
    logic        branch_taken;

    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic [2:0]  state;
    logic        illegal;
    logic        timeout;
    logic [31:0] instret;

    modport slave (
        input  opcode, imem_ack, dmem_ack, branch_taken,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
               rf_we, wb_sel, alu_a_sel, alu_b_sel, state,
               illegal, timeout, instret
    );

    modport master (
        output opcode, imem_ack, dmem_ack, branch_taken,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
               rf_we, wb_sel, alu_a_sel, alu_b_sel, state,
               illegal, timeout, instret
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl
//  Description : Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for RV32I.
//                Handshakes with instruction and data memory (req/ack),
//                drives PC/IR/register-file strobes and mux selects, traps
//                on an illegal opcode or a memory-ack timeout.
//  Parameters  : TIMEOUT - max wait cycles for an ack before TRAP
//                TO_W    - width of the shared wait counter
//  Ports       : CLK  - clock, rising edge
//                RST  - asynchronous active-low reset
//                bus  - mc_ctrl_if.slave (opcode/acks in, strobes/status out)
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  wire logic  CLK,
    input  wire logic  RST,
    mc_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0]      c_OP_R     = 7'b0110011;
    localparam logic [6:0]      c_OP_I     = 7'b0010011;
    localparam logic [6:0]      c_OP_LD    = 7'b0000011;
    localparam logic [6:0]      c_OP_ST    = 7'b0100011;
    localparam logic [6:0]      c_OP_BR    = 7'b1100011;
    localparam logic [6:0]      c_OP_JAL   = 7'b1101111;
    localparam logic [6:0]      c_OP_JALR  = 7'b1100111;
    localparam logic [6:0]      c_OP_LUI   = 7'b0110111;
    localparam logic [6:0]      c_OP_AUIPC = 7'b0010111;
    localparam logic [TO_W-1:0] c_TIMEOUT  = TO_W'(TIMEOUT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TO_W-1:0]   r_wait;
    logic              r_illegal;
    logic              r_timeout;
    logic [31:0]       r_instret;

    // Opcode class decode; IR holds the opcode from DECODE until retirement.
    logic w_op_r, w_op_i, w_op_ld, w_op_st, w_op_br;
    logic w_op_jal, w_op_jalr, w_op_lui, w_op_auipc, w_legal;

    assign w_op_r     = (bus.opcode == c_OP_R);
    assign w_op_i     = (bus.opcode == c_OP_I);
    assign w_op_ld    = (bus.opcode == c_OP_LD);
    assign w_op_st    = (bus.opcode == c_OP_ST);
    assign w_op_br    = (bus.opcode == c_OP_BR);
    assign w_op_jal   = (bus.opcode == c_OP_JAL);
    assign w_op_jalr  = (bus.opcode == c_OP_JALR);
    assign w_op_lui   = (bus.opcode == c_OP_LUI);
    assign w_op_auipc = (bus.opcode == c_OP_AUIPC);
    assign w_legal    = w_op_r | w_op_i | w_op_ld | w_op_st | w_op_br |
                        w_op_jal | w_op_jalr | w_op_lui | w_op_auipc;

    logic       w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we;
    logic [1:0] w_pc_sel, w_wb_sel, w_alu_a_sel;
    logic       w_rf_we, w_alu_b_sel;
    logic       w_wait_inc, w_set_ill, w_set_to, w_retire;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_sel    = 2'd0;
        w_rf_we     = 1'b0;
        w_wb_sel    = 2'd0;
        w_alu_a_sel = 2'd0;
        w_alu_b_sel = 1'b0;
        w_wait_inc  = 1'b0;
        w_set_ill   = 1'b0;
        w_set_to    = 1'b0;
        w_retire    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ack) begin
                    w_ir_we     = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (r_wait == c_TIMEOUT) begin
                    w_set_to    = 1'b1;
                    w_state_nxt = S_TRAP;
                end else begin
                    w_wait_inc  = 1'b1;
                end
            end

            S_DECODE: begin
                if (w_legal) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_set_ill   = 1'b1;
                    w_state_nxt = S_TRAP;
                end
            end

            S_EXEC: begin
                w_alu_a_sel = w_op_auipc ? 2'd1 : (w_op_lui ? 2'd2 : 2'd0);
                w_alu_b_sel = ~(w_op_r | w_op_br);
                if (w_op_br) begin
                    // Branches resolve and retire here; no WB cycle.
                    w_pc_we     = 1'b1;
                    w_pc_sel    = bus.branch_taken ? 2'd1 : 2'd0;
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (w_op_ld | w_op_st) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end

            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_op_st;
                if (bus.dmem_ack) begin
                    if (w_op_st) begin
                        // Stores retire on the data ack; nothing to write back.
                        w_pc_we     = 1'b1;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (r_wait == c_TIMEOUT) begin
                    w_set_to    = 1'b1;
                    w_state_nxt = S_TRAP;
                end else begin
                    w_wait_inc  = 1'b1;
                end
            end

            S_WB: begin
                w_rf_we     = 1'b1;
                w_wb_sel    = w_op_ld ? 2'd1 : ((w_op_jal | w_op_jalr) ? 2'd2 : 2'd0);
                w_pc_we     = 1'b1;
                w_pc_sel    = w_op_jal ? 2'd1 : (w_op_jalr ? 2'd2 : 2'd0);
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end

            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end

            default: begin
                w_state_nxt = S_TRAP;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, wait counter, sticky flags, retired-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            // Shared by FETCH and MEM: any state change restarts the count.
            if (w_state_nxt != r_state) begin
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_set_ill) begin
                r_illegal <= 1'b1;
            end
            if (w_set_to) begin
                r_timeout <= 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // Strobes are forced low while reset is asserted, independent of the
    // clock, so an in-flight memory request is withdrawn immediately.
    assign bus.imem_req  = RST & w_imem_req;
    assign bus.dmem_req  = RST & w_dmem_req;
    assign bus.dmem_we   = RST & w_dmem_we;
    assign bus.ir_we     = RST & w_ir_we;
    assign bus.pc_we     = RST & w_pc_we;
    assign bus.rf_we     = RST & w_rf_we;
    assign bus.alu_b_sel = RST & w_alu_b_sel;
    assign bus.pc_sel    = RST ? w_pc_sel    : 2'd0;
    assign bus.wb_sel    = RST ? w_wb_sel    : 2'd0;
    assign bus.alu_a_sel = RST ? w_alu_a_sel : 2'd0;
    assign bus.state     = r_state;
    assign bus.illegal   = r_illegal;
    assign bus.timeout   = r_timeout;
    assign bus.instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl
//  Description : Directed self-checking bench for mc_ctrl. Each driven cycle
//                pushes its expected output vector to a scoreboard queue,
//                which is popped and compared once the DUT outputs settle.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mc_ctrl;

    localparam int TIMEOUT = 15;
    localparam int TO_W    = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef logic [15:0] vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    mc_ctrl_if bus();

    mc_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    vec_t exp_q[$];
    int   errors      = 0;
    int   checks      = 0;
    int   exp_instret = 0;

    // {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_a_sel, alu_b_sel}
    function automatic vec_t mk(input logic [2:0] st, input logic ir, input logic dr,
                                input logic dw, input logic iw, input logic pw,
                                input logic [1:0] ps, input logic rw, input logic [1:0] ws,
                                input logic [1:0] aa, input logic ab);
        return {st, ir, dr, dw, iw, pw, ps, rw, ws, aa, ab};
    endfunction

    function automatic vec_t obs();
        return {bus.state, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we,
                bus.pc_sel, bus.rf_we, bus.wb_sel, bus.alu_a_sel, bus.alu_b_sel};
    endfunction

    task automatic check_vec(input string tag);
        vec_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed=%h expected=<scoreboard empty>", tag, obs());
        end else begin
            e = exp_q.pop_front();
            assert (obs() === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs(), e);
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, record the expected
    // outputs, then compare once the combinational decode has settled.
    task automatic cycle(input logic [6:0] op, input logic ia, input logic da,
                         input logic br, input vec_t e, input string tag);
        @(negedge CLK);
        bus.opcode       = op;
        bus.imem_ack     = ia;
        bus.dmem_ack     = da;
        bus.branch_taken = br;
        exp_q.push_back(e);
        #1;
        check_vec(tag);
    endtask

    // Reference model of one instruction's cycle sequence.
    task automatic do_instr(input logic [6:0] op, input int iwait, input int dwait,
                            input logic br, input logic stray);
        logic       is_ld, is_st, is_br, is_r, legal;
        logic [1:0] aa, ws, ps;
        logic       ab;
        is_ld = (op == OP_LD);
        is_st = (op == OP_ST);
        is_br = (op == OP_BR);
        is_r  = (op == OP_R);
        legal = (op == OP_R) || (op == OP_I) || is_ld || is_st || is_br ||
                (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
        aa = (op == OP_AUIPC) ? 2'd1 : ((op == OP_LUI) ? 2'd2 : 2'd0);
        ab = !(is_r || is_br);
        ws = is_ld ? 2'd1 : (((op == OP_JAL) || (op == OP_JALR)) ? 2'd2 : 2'd0);
        ps = (op == OP_JAL) ? 2'd1 : ((op == OP_JALR) ? 2'd2 : 2'd0);

        for (int i = 0; i < iwait; i++)
            cycle(op, 1'b0, stray, 1'b0, mk(3'd0,1,0,0,0,0,2'd0,0,2'd0,2'd0,0), "fetch_wait");
        cycle(op, 1'b1, stray, 1'b0, mk(3'd0,1,0,0,1,0,2'd0,0,2'd0,2'd0,0), "fetch_ack");
        cycle(op, stray, stray, 1'b0, mk(3'd1,0,0,0,0,0,2'd0,0,2'd0,2'd0,0), "decode");
        if (legal) begin
            cycle(op, stray, stray, br,
                  mk(3'd2,0,0,0,0,is_br,(is_br ? {1'b0,br} : 2'd0),0,2'd0,aa,ab), "exec");
            if (is_br) exp_instret++;
            if (is_ld || is_st) begin
                for (int i = 0; i < dwait; i++)
                    cycle(op, stray, 1'b0, 1'b0, mk(3'd3,0,1,is_st,0,0,2'd0,0,2'd0,2'd0,0), "mem_wait");
                cycle(op, stray, 1'b1, 1'b0, mk(3'd3,0,1,is_st,0,is_st,2'd0,0,2'd0,2'd0,0), "mem_ack");
                if (is_st) exp_instret++;
            end
            if (!is_br && !is_st) begin
                cycle(op, stray, stray, 1'b0, mk(3'd4,0,0,0,0,1,ps,1,ws,2'd0,0), "wb");
                exp_instret++;
            end
        end
    endtask

    task automatic check_instret(input string tag);
        @(posedge CLK);
        #1;
        check_val(tag, bus.instret, 32'(exp_instret));
    endtask

    // Assert reset between clock edges and check everything drops at once.
    task automatic reset_pulse(input string tag);
        #1 RST = 1'b0;
        #1;
        exp_instret = 0;
        exp_q.push_back(mk(3'd0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0));
        check_vec({tag, "_outputs"});
        check_val({tag, "_instret"}, bus.instret, 32'd0);
        check_val({tag, "_flags"}, {30'd0, bus.illegal, bus.timeout}, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    initial begin
        bus.opcode       = OP_R;
        bus.imem_ack     = 1'b0;
        bus.dmem_ack     = 1'b0;
        bus.branch_taken = 1'b0;

        // Reset state
        #2;
        exp_q.push_back(mk(3'd0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0));
        check_vec("reset_outputs");
        check_val("reset_instret", bus.instret, 32'd0);
        check_val("reset_flags", {30'd0, bus.illegal, bus.timeout}, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b1;

        // Three zero-wait R-type instructions
        for (int k = 0; k < 3; k++) do_instr(OP_R, 0, 0, 1'b0, 1'b0);
        check_instret("instret_after_3R");

        // LD with data ack delayed 3 cycles
        do_instr(OP_LD, 0, 3, 1'b0, 1'b0);
        check_instret("instret_after_ld");

        // Branches taken / not taken, with stray acks that must be ignored
        do_instr(OP_BR, 0, 0, 1'b1, 1'b1);
        do_instr(OP_BR, 0, 0, 1'b0, 1'b1);
        check_instret("instret_after_br");

        // Remaining instruction classes, with some fetch wait states
        do_instr(OP_I,     2, 0, 1'b0, 1'b0);
        do_instr(OP_JAL,   1, 0, 1'b0, 1'b1);
        do_instr(OP_JALR,  0, 0, 1'b0, 1'b0);
        do_instr(OP_LUI,   3, 0, 1'b0, 1'b0);
        do_instr(OP_AUIPC, 0, 0, 1'b0, 1'b1);
        do_instr(OP_ST,    0, 2, 1'b0, 1'b0);
        do_instr(OP_LD,    TIMEOUT - 1, TIMEOUT, 1'b0, 1'b0);
        check_instret("instret_after_mix");

        // Illegal opcode traps right after DECODE and stays there
        do_instr(OP_BAD, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++)
            cycle(OP_BAD, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  mk(3'd5,0,0,0,0,0,2'd0,0,2'd0,2'd0,0), "trap_illegal");
        check_val("illegal_flag", {30'd0, bus.illegal, bus.timeout}, 32'd2);
        reset_pulse("rst_after_illegal");

        // Fetch timeout: request held for TIMEOUT+1 cycles, then TRAP
        for (int k = 0; k <= TIMEOUT; k++)
            cycle(OP_R, 1'b0, 1'b0, 1'b0, mk(3'd0,1,0,0,0,0,2'd0,0,2'd0,2'd0,0), "fetch_timeout_wait");
        cycle(OP_R, 1'b0, 1'b0, 1'b0, mk(3'd5,0,0,0,0,0,2'd0,0,2'd0,2'd0,0), "fetch_timeout_trap");
        check_val("timeout_flag", {30'd0, bus.illegal, bus.timeout}, 32'd1);
        reset_pulse("rst_after_timeout");

        // Memory timeout: dmem_ack never arrives
        do_instr(OP_R, 0, 0, 1'b0, 1'b0);
        cycle(OP_LD, 1'b1, 1'b0, 1'b0, mk(3'd0,1,0,0,1,0,2'd0,0,2'd0,2'd0,0), "mto_fetch");
        cycle(OP_LD, 1'b0, 1'b0, 1'b0, mk(3'd1,0,0,0,0,0,2'd0,0,2'd0,2'd0,0), "mto_decode");
        cycle(OP_LD, 1'b0, 1'b0, 1'b0, mk(3'd2,0,0,0,0,0,2'd0,0,2'd0,2'd0,1), "mto_exec");
        for (int k = 0; k <= TIMEOUT; k++)
            cycle(OP_LD, 1'b1, 1'b0, 1'b0, mk(3'd3,0,1,0,0,0,2'd0,0,2'd0,2'd0,0), "mto_wait");
        cycle(OP_LD, 1'b0, 1'b1, 1'b0, mk(3'd5,0,0,0,0,0,2'd0,0,2'd0,2'd0,0), "mto_trap");
        check_val("mem_timeout_flag", {30'd0, bus.illegal, bus.timeout}, 32'd1);
        reset_pulse("rst_after_mto");

        // Reset asserted mid-MEM of a store
        do_instr(OP_R, 0, 0, 1'b0, 1'b0);
        check_instret("instret_before_st");
        cycle(OP_ST, 1'b1, 1'b0, 1'b0, mk(3'd0,1,0,0,1,0,2'd0,0,2'd0,2'd0,0), "st_fetch");
        cycle(OP_ST, 1'b0, 1'b0, 1'b0, mk(3'd1,0,0,0,0,0,2'd0,0,2'd0,2'd0,0), "st_decode");
        cycle(OP_ST, 1'b0, 1'b0, 1'b0, mk(3'd2,0,0,0,0,0,2'd0,0,2'd0,2'd0,1), "st_exec");
        cycle(OP_ST, 1'b0, 1'b0, 1'b0, mk(3'd3,0,1,1,0,0,2'd0,0,2'd0,2'd0,0), "st_mem");
        reset_pulse("rst_mid_mem");

        // Restart from FETCH after reset
        do_instr(OP_R, 0, 0, 1'b0, 1'b0);
        check_instret("instret_after_restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
